// File: rtl/rom_loader.sv
// Program-store loader: turns 16-bit hps_io download words into paced byte writes,
// holds the CPU in reset during and after a download, and keeps count/checksum status.
module rom_loader #(
    parameter int ADDR_W      = 12,
    parameter int INDEX       = 0,
    parameter int HOLD_CYCLES = 256
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic              rom_wr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              copy_in_progress,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum,
    output logic              overflow
);

    localparam int                HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0]   HOLD_LOAD = HC_W'(HOLD_CYCLES);
    localparam logic [HC_W-1:0]   HC_ONE    = {{(HC_W-1){1'b0}}, 1'b1};
    localparam logic [HC_W-1:0]   HC_ZERO   = {HC_W{1'b0}};
    localparam logic [7:0]        INDEX_V   = 8'(INDEX);
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        WR_LO  = 3'd2,
        WR_HI  = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [HC_W-1:0]     hold_cnt_r;
    logic [HC_W-1:0]     hold_cnt_s;
    logic [ADDR_W-2:0]   word_addr_r;
    logic [7:0]          data_hi_r;
    logic                oor_r;

    logic                match_s;
    logic                in_range_s;
    logic                start_s;
    logic                enter_s;
    logic                wr_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [7:0]          wr_data_s;
    logic                unused_s;

    assign match_s    = ioctl_download && (ioctl_index == INDEX_V);
    assign in_range_s = (ioctl_addr[24:ADDR_W] == {(25-ADDR_W){1'b0}});
    assign start_s    = (state_r == ACTIVE) && match_s && ioctl_wr;
    assign enter_s    = ((state_r == IDLE) || (state_r == HOLD)) && match_s;
    // Words are always even-aligned, so the low address bit carries no information.
    assign unused_s   = ioctl_addr[0];

    // Next-state and hold-counter logic.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (match_s) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (!match_s) begin
                    state_s    = HOLD;
                    hold_cnt_s = HOLD_LOAD;
                end else if (ioctl_wr) begin
                    state_s = WR_LO;
                end else begin
                    state_s = ACTIVE;
                end
            end
            WR_LO: begin
                state_s = WR_HI;
            end
            // A download that ended mid-word finishes both bytes before holding.
            WR_HI: begin
                if (match_s) begin
                    state_s = ACTIVE;
                end else begin
                    state_s    = HOLD;
                    hold_cnt_s = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (match_s) begin
                    state_s    = ACTIVE;
                    hold_cnt_s = HC_ZERO;
                end else if (hold_cnt_r <= HC_ONE) begin
                    state_s    = IDLE;
                    hold_cnt_s = HC_ZERO;
                end else begin
                    state_s    = HOLD;
                    hold_cnt_s = hold_cnt_r - HC_ONE;
                end
            end
            default: begin
                state_s    = HOLD;
                hold_cnt_s = HOLD_LOAD;
            end
        endcase
    end

    // Byte-write selection: low byte on word acceptance, high byte one cycle later.
    always_comb begin
        wr_s      = 1'b0;
        wr_addr_s = rom_addr;
        wr_data_s = rom_data;
        if (start_s) begin
            wr_s      = in_range_s;
            wr_addr_s = {ioctl_addr[ADDR_W-1:1], 1'b0};
            wr_data_s = ioctl_dout[7:0];
        end else if (state_r == WR_LO) begin
            wr_s      = ~oor_r;
            wr_addr_s = {word_addr_r, 1'b1};
            wr_data_s = data_hi_r;
        end else begin
            wr_s      = 1'b0;
            wr_addr_s = rom_addr;
            wr_data_s = rom_data;
        end
    end

    // State, handshake and CPU-hold registers; outputs reflect the state being entered.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r          <= HOLD;
            hold_cnt_r       <= HOLD_LOAD;
            ioctl_wait       <= 1'b0;
            copy_in_progress <= 1'b0;
            cpu_hold         <= 1'b1;
        end else begin
            state_r          <= state_s;
            hold_cnt_r       <= hold_cnt_s;
            ioctl_wait       <= (state_s == WR_LO) || (state_s == WR_HI);
            copy_in_progress <= (state_s == ACTIVE) || (state_s == WR_LO) || (state_s == WR_HI);
            cpu_hold         <= (state_s != IDLE);
        end
    end

    // Write port, latched word and download status counters.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rom_wr      <= 1'b0;
            rom_addr    <= {ADDR_W{1'b0}};
            rom_data    <= 8'h00;
            word_addr_r <= {(ADDR_W-1){1'b0}};
            data_hi_r   <= 8'h00;
            oor_r       <= 1'b0;
            byte_count  <= {(ADDR_W+1){1'b0}};
            checksum    <= 8'h00;
            overflow    <= 1'b0;
        end else begin
            rom_wr   <= wr_s;
            rom_addr <= wr_addr_s;
            rom_data <= wr_data_s;
            if (start_s) begin
                word_addr_r <= ioctl_addr[ADDR_W-1:1];
                data_hi_r   <= ioctl_dout[15:8];
                oor_r       <= ~in_range_s;
            end
            if (enter_s) begin
                byte_count <= {(ADDR_W+1){1'b0}};
                checksum   <= 8'h00;
                overflow   <= 1'b0;
            end else begin
                if (wr_s) begin
                    if (byte_count != COUNT_MAX) begin
                        byte_count <= byte_count + COUNT_ONE;
                    end
                    checksum <= checksum + wr_data_s;
                end
                if (start_s && !in_range_s) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed vector table, full-image download, random download
// against a byte-image model, and reset/hold corner cases.
module tb_rom_loader;

    localparam int ADDR_W = 12;
    localparam int HOLD   = 256;
    localparam int MEM    = 4096;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic              ioctl_wait;
    logic              rom_wr;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              copy_in_progress;
    logic              cpu_hold;
    logic [ADDR_W:0]   byte_count;
    logic [7:0]        checksum;
    logic              overflow;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.ADDR_W(ADDR_W), .INDEX(0), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_wr(rom_wr),
        .rom_addr(rom_addr), .rom_data(rom_data), .copy_in_progress(copy_in_progress),
        .cpu_hold(cpu_hold), .byte_count(byte_count), .checksum(checksum),
        .overflow(overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Captured program-store writes.
    logic [7:0] cap_mem [MEM];
    int         cap_cnt [MEM];
    int         cap_total = 0;
    logic       clr_req = 1'b0;

    always @(negedge clk_sys) begin
        if (clr_req) begin
            for (int i = 0; i < MEM; i++) cap_cnt[i] <= 0;
            cap_total <= 0;
        end else if (rom_wr === 1'b1) begin
            cap_mem[rom_addr] <= rom_data;
            cap_cnt[rom_addr] <= cap_cnt[rom_addr] + 1;
            cap_total         <= cap_total + 1;
        end
    end

    // Reference model: expected byte image and status derived from the words sent.
    logic [7:0] exp_mem [MEM];
    int         exp_cnt [MEM];
    int         exp_total;
    int         exp_sum;
    logic       exp_ov;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] dout;
        logic        exp_wr;
        logic [11:0] lo_addr;
        logic [7:0]  lo_data;
        logic [11:0] hi_addr;
        logic [7:0]  hi_data;
        logic        exp_ov;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_capture();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM; i++) exp_cnt[i] = 0;
        exp_total = 0;
        exp_sum   = 0;
        exp_ov    = 1'b0;
    endtask

    task automatic model_word(input logic [24:0] a, input logic [15:0] d);
        int base;
        int b;
        base = int'(a) & ~1;
        if (base < MEM) begin
            for (int k = 0; k < 2; k++) begin
                b = (k == 0) ? int'(d & 16'h00FF) : int'(d >> 8);
                exp_mem[base + k] = 8'(b);
                exp_cnt[base + k]++;
                exp_total++;
                exp_sum = (exp_sum + b) % 256;
            end
        end else begin
            exp_ov = 1'b1;
        end
    endtask

    task automatic compare_image(input string name);
        int m;
        m = 0;
        for (int i = 0; i < MEM; i++) begin
            if (cap_cnt[i] != exp_cnt[i]) m++;
            else if (exp_cnt[i] > 0 && cap_mem[i] !== exp_mem[i]) m++;
        end
        check(name, m, 0);
    endtask

    // Issues one word and returns once ioctl_wait has released (bounded).
    task automatic send_word(input logic [24:0] a, input logic [15:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ioctl_wait !== 1'b1) break;
            step();
        end
        check("wait_release", ioctl_wait, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < HOLD + 64; i++) begin
            @(negedge clk_sys);
            if (cpu_hold === 1'b0) break;
        end
        check(name, cpu_hold, 1'b0);
    endtask

    int   n;
    int   bad;
    int   base_total;
    int   e_cnt;
    int   e_sum;
    logic [24:0] ra;
    logic [15:0] rd;

    initial begin
        vecs[0] = '{25'h0000010, 16'hBEEF, 1'b1, 12'h010, 8'hEF, 12'h011, 8'hBE, 1'b0};
        vecs[1] = '{25'h0000021, 16'hA55A, 1'b1, 12'h020, 8'h5A, 12'h021, 8'hA5, 1'b0};
        vecs[2] = '{25'h0000FFE, 16'h1234, 1'b1, 12'hFFE, 8'h34, 12'hFFF, 8'h12, 1'b0};
        vecs[3] = '{25'h0001000, 16'hCAFE, 1'b0, 12'h000, 8'h00, 12'h000, 8'h00, 1'b1};
        vecs[4] = '{25'h1FFFFFE, 16'h0101, 1'b0, 12'h000, 8'h00, 12'h000, 8'h00, 1'b1};
        vecs[5] = '{25'h0000000, 16'h00FF, 1'b1, 12'h000, 8'hFF, 12'h001, 8'h00, 1'b1};

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
        ioctl_wr = 1'b0; ioctl_addr = 25'h0; ioctl_dout = 16'h0;

        // Reset state, then hold length after release.
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_outputs", {ioctl_wait, rom_wr, copy_in_progress, overflow}, 4'b0000);
        check("rst_counts", {byte_count, checksum, rom_addr, rom_data}, 0);
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        n = 0; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if ({ioctl_wait, rom_wr, copy_in_progress, overflow} != 4'b0000) bad++;
            if (cpu_hold !== 1'b1) break;
            n++;
        end
        check("hold_after_reset", n, HOLD);
        check("quiet_after_reset", bad, 0);

        // Vector table within one accepted download.
        step();
        ioctl_download = 1'b1;
        step();
        check("dl_start_copy", {copy_in_progress, cpu_hold}, 2'b11);
        e_cnt = 0; e_sum = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            ioctl_addr = vecs[i].addr; ioctl_dout = vecs[i].dout; ioctl_wr = 1'b1;
            step();
            ioctl_wr = 1'b0;
            @(negedge clk_sys);
            check($sformatf("v%0d_lo_wait", i), ioctl_wait, 1'b1);
            check($sformatf("v%0d_lo_wr", i), rom_wr, vecs[i].exp_wr);
            if (vecs[i].exp_wr) check($sformatf("v%0d_lo_ad", i), {rom_addr, rom_data}, {vecs[i].lo_addr, vecs[i].lo_data});
            step();
            @(negedge clk_sys);
            check($sformatf("v%0d_hi_wait", i), ioctl_wait, 1'b1);
            check($sformatf("v%0d_hi_wr", i), rom_wr, vecs[i].exp_wr);
            if (vecs[i].exp_wr) check($sformatf("v%0d_hi_ad", i), {rom_addr, rom_data}, {vecs[i].hi_addr, vecs[i].hi_data});
            if (vecs[i].exp_wr) begin
                e_cnt += 2;
                e_sum = (e_sum + int'(vecs[i].lo_data) + int'(vecs[i].hi_data)) % 256;
            end
            step();
            @(negedge clk_sys);
            check($sformatf("v%0d_end_idle", i), {ioctl_wait, rom_wr}, 2'b00);
            check($sformatf("v%0d_count", i), byte_count, e_cnt);
            check($sformatf("v%0d_csum", i), checksum, e_sum);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ov);
        end
        step();
        ioctl_download = 1'b0;
        wait_idle("table_idle");

        // Non-matching index is ignored; status persists.
        step();
        ioctl_index = 8'h01; ioctl_download = 1'b1;
        ioctl_addr = 25'h030; ioctl_dout = 16'h5555; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            if ({ioctl_wait, rom_wr, copy_in_progress, cpu_hold} != 4'b0000) bad++;
        end
        check("nomatch_quiet", bad, 0);
        check("persist_count", byte_count, e_cnt);
        check("persist_csum", checksum, e_sum);
        check("persist_ovf", overflow, 1'b1);
        step();
        ioctl_download = 1'b0; ioctl_index = 8'h00;

        // Full 4096-byte image, back-to-back words.
        clear_capture();
        model_clear();
        ioctl_download = 1'b1;
        step();
        check("full_start_clears", {overflow, byte_count, checksum}, 0);
        for (int w = 0; w < MEM / 2; w++) begin
            ra = 25'(2 * w);
            rd = {8'((2 * w + 1) % 256), 8'((2 * w) % 256)};
            send_word(ra, rd);
            model_word(ra, rd);
        end
        compare_image("full_image");
        check("full_count", byte_count, 4096);
        check("full_csum", checksum, 8'h00);
        check("full_ovf", overflow, 1'b0);
        send_word(25'h0, 16'h0302);
        model_word(25'h0, 16'h0302);
        check("sat_count", byte_count, (exp_total > MEM) ? MEM : exp_total);
        check("sat_csum", checksum, exp_sum);
        ioctl_download = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (copy_in_progress === 1'b0) break;
        end
        check("copy_drop", copy_in_progress, 1'b0);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cpu_hold !== 1'b1) break;
            n++;
            @(negedge clk_sys);
        end
        check("hold_after_dl", n, HOLD);

        // Random download against the image model.
        step();
        clear_capture();
        model_clear();
        ioctl_download = 1'b1;
        step();
        for (int w = 0; w < 150; w++) begin
            if ($urandom_range(0, 4) == 0) ra = 25'($urandom_range(MEM, 33554431));
            else ra = 25'($urandom_range(0, MEM - 1));
            rd = 16'($urandom);
            send_word(ra, rd);
            model_word(ra, rd);
            repeat ($urandom_range(0, 3)) step();
        end
        compare_image("rand_image");
        check("rand_count", byte_count, (exp_total > MEM) ? MEM : exp_total);
        check("rand_csum", checksum, exp_sum);
        check("rand_ovf", overflow, exp_ov);
        ioctl_download = 1'b0;
        wait_idle("rand_idle");

        // Reset during WR_LO abandons the high byte; then a clean restart.
        step();
        ioctl_download = 1'b1;
        step();
        ioctl_addr = 25'h020; ioctl_dout = 16'h1234; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk_sys);
        check("rst_mid_lo", {rom_wr, rom_addr, rom_data}, {1'b1, 12'h020, 8'h34});
        step();
        base_total = cap_total;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (rom_wr !== 1'b0) bad++;
        end
        check("rst_mid_nowr", bad, 0);
        check("rst_mid_total", cap_total, base_total);
        check("rst_mid_ctrl", {cpu_hold, copy_in_progress, ioctl_wait}, 3'b100);
        check("rst_mid_counts", {overflow, byte_count, checksum}, 0);
        step();
        ioctl_download = 1'b0;
        reset_n = 1'b1;
        step();
        ioctl_download = 1'b1;
        step();
        check("restart_copy", copy_in_progress, 1'b1);
        send_word(25'h040, 16'h0102);
        check("restart_count", byte_count, 2);
        check("restart_csum", checksum, 8'h03);
        check("restart_mem", {cap_mem[12'h040], cap_mem[12'h041]}, 16'h0201);
        ioctl_download = 1'b0;
        wait_idle("restart_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
